ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue_pkg.sv | 18 +
 rtl/ifetch_queue_if.sv | 54 +++++
 rtl/ifetch_queue_fifo.sv | 56 +++++
 rtl/ifetch_queue.sv | 113 +++++++++++
 tb/tb_ifetch_queue.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue and its entry buffer.
package ifetch_queue_pkg;

   localparam int unsigned IFQ_XLEN  = 32;
   localparam int unsigned IFQ_ILEN  = 32;
   localparam int unsigned IFQ_DEPTH = 4;

   typedef struct packed {
      logic [IFQ_ILEN-1:0] instr;
      logic [IFQ_XLEN-1:0] pc;
   } ifq_entry_t;

   typedef enum logic {
      IFQ_BOOT,
      IFQ_RUN
   } ifq_state_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: boot PC, icache request/response channel and the dec handshake.
interface ifetch_queue_if
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned XLEN = IFQ_XLEN,
   parameter int unsigned ILEN = IFQ_ILEN
);

   logic [XLEN-1:0] reset_adr_i;
   logic            icache_req_v_o;
   logic [XLEN-1:0] icache_adr_o;
   logic            icache_gnt_i;
   logic            icache_rsp_v_i;
   logic [ILEN-1:0] icache_instr_i;
   logic            branch_v_q_i;
   logic [XLEN-1:0] pc_data_q_i;
   logic            instr_v_o;
   logic [ILEN-1:0] instr_o;
   logic [XLEN-1:0] pc_o;
   logic            dec_ready_i;

   // Fetch-queue side
   modport master (
      input  reset_adr_i,
      output icache_req_v_o,
      output icache_adr_o,
      input  icache_gnt_i,
      input  icache_rsp_v_i,
      input  icache_instr_i,
      input  branch_v_q_i,
      input  pc_data_q_i,
      output instr_v_o,
      output instr_o,
      output pc_o,
      input  dec_ready_i
   );

   // Environment side (icache, exe, dec)
   modport slave (
      output reset_adr_i,
      input  icache_req_v_o,
      input  icache_adr_o,
      output icache_gnt_i,
      output icache_rsp_v_i,
      output icache_instr_i,
      output branch_v_q_i,
      output pc_data_q_i,
      input  instr_v_o,
      input  instr_o,
      input  pc_o,
      output dec_ready_i
   );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of {instr, pc}; DEPTH must be a power of two.
module ifq_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IFQ_DEPTH,
   localparam int unsigned CW   = $clog2(DEPTH + 1),
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  ifq_entry_t    push_data,
   input  logic          pop,
   output ifq_entry_t    head,
   output logic [CW-1:0] count
);

   ifq_entry_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          pop_ok;

   assign pop_ok = pop && (count != '0);
   assign head   = mem[rd_ptr];

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: credit-limited icache requests feeding an in-order queue towards dec.
// Define IFQ_BYPASS_EN to forward a response straight to dec when the queue is empty.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned XLEN            = IFQ_XLEN,
   parameter int unsigned ILEN            = IFQ_ILEN,
   parameter int unsigned DEPTH           = IFQ_DEPTH,
   parameter int unsigned MAX_OUTSTANDING = DEPTH
) (
   input  logic           clk,
   input  logic           reset,
   ifetch_queue_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   ifq_state_t      state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] target;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   ifq_entry_t      head;
   ifq_entry_t      push_data;
   logic            flush;
   logic            req_v;
   logic            fire;
   logic            keep;
   logic            bypass;
   logic            push;
   logic            pop;

   assign flush  = bus.branch_v_q_i;
   assign target = {bus.pc_data_q_i[XLEN-1:2], 2'b00};

   // Credits count both queued entries and requests still in flight.
   assign req_v = (state == IFQ_RUN) && !flush
                  && ((32'(count) + 32'(outstanding)) < DEPTH)
                  && (32'(outstanding) < MAX_OUTSTANDING);
   assign fire  = req_v && bus.icache_gnt_i;
   assign keep  = bus.icache_rsp_v_i && (drop_cnt == '0);

`ifdef IFQ_BYPASS_EN
   assign bypass = keep && !flush && (count == '0) && bus.dec_ready_i;
`else
   assign bypass = 1'b0;
`endif

   assign push      = keep && !flush && !bypass;
   assign pop       = (count != '0) && !flush && bus.dec_ready_i;
   assign push_data = '{instr: bus.icache_instr_i, pc: rsp_pc};

   assign bus.icache_req_v_o = req_v;
   assign bus.icache_adr_o   = fetch_pc;
   assign bus.instr_v_o      = !flush && ((count != '0) || bypass);
   assign bus.instr_o        = bypass ? bus.icache_instr_i : head.instr;
   assign bus.pc_o           = bypass ? rsp_pc : head.pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IFQ_BOOT;
         fetch_pc    <= '0;
         rsp_pc      <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (state == IFQ_BOOT) begin
         fetch_pc <= bus.reset_adr_i;
         rsp_pc   <= bus.reset_adr_i;
         state    <= IFQ_RUN;
      end else begin
         outstanding <= outstanding + CW'(fire) - CW'(bus.icache_rsp_v_i);
         if (flush) begin
            // Everything requested so far is stale, including a response arriving now.
            fetch_pc <= target;
            rsp_pc   <= target;
            drop_cnt <= outstanding - CW'(bus.icache_rsp_v_i);
         end else begin
            if (fire) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (bus.icache_rsp_v_i) begin
               if (drop_cnt != '0) begin
                  drop_cnt <= drop_cnt - CW'(1);
               end else begin
                  rsp_pc <= rsp_pc + XLEN'(4);
               end
            end
         end
      end
   end

   ifq_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .head     (head),
      .count    (count)
   );

   a_rsp_has_credit: assert property (@(posedge clk) disable iff (reset)
      bus.icache_rsp_v_i |-> (outstanding != '0));

   a_drop_bounded: assert property (@(posedge clk) disable iff (reset)
      drop_cnt <= outstanding);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a queue-level reference model and per-cycle compare.
module tb_ifetch_queue;
   import ifetch_queue_pkg::*;

   localparam int unsigned DEPTH = 4;
`ifdef IFQ_BYPASS_EN
   localparam int FIRST_LAT = 2;
`else
   localparam int FIRST_LAT = 3;
`endif

   typedef struct { logic [31:0] adr; logic dropped; } req_t;
   typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   ifetch_queue_if #(.XLEN(32), .ILEN(32)) bus ();

   ifetch_queue #(
      .XLEN(32),
      .ILEN(32),
      .DEPTH(DEPTH),
      .MAX_OUTSTANDING(DEPTH)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rel_cyc = 0;
   int first_v = -1;
   int grants = 0;

   // Reference model: icache in-flight list doubles as the icache itself.
   logic        m_boot = 1'b1;
   logic [31:0] m_fetch = '0;
   req_t        inflight[$];
   ent_t        mq[$];
   ent_t        deliv[$];
   logic [31:0] gnt_adr[$];

   function automatic logic [31:0] ifn(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   function automatic logic m_req();
      return !reset && !m_boot && !bus.branch_v_q_i
             && ((mq.size() + inflight.size()) < DEPTH)
             && (inflight.size() < DEPTH);
   endfunction

   function automatic logic m_bypass();
`ifdef IFQ_BYPASS_EN
      return !reset && !m_boot && !bus.branch_v_q_i && bus.dec_ready_i
             && (mq.size() == 0) && bus.icache_rsp_v_i
             && (inflight.size() > 0) && !inflight[0].dropped;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic m_instr_v();
      return !reset && !m_boot && !bus.branch_v_q_i && ((mq.size() > 0) || m_bypass());
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1;
      m_fetch = '0;
      inflight.delete();
      mq.delete();
   endtask

   task automatic model_update();
      logic fire, byp, pop_q;
      req_t r;
      if (reset) begin
         model_reset();
      end else if (m_boot) begin
         m_boot = 1'b0;
         m_fetch = bus.reset_adr_i;
      end else begin
         fire  = m_req() && bus.icache_gnt_i;
         byp   = m_bypass();
         pop_q = (mq.size() > 0) && !bus.branch_v_q_i && bus.dec_ready_i;
         r = '{adr: '0, dropped: 1'b1};
         if (bus.icache_rsp_v_i && inflight.size() > 0) r = inflight.pop_front();
         if (bus.branch_v_q_i) begin
            mq.delete();
            foreach (inflight[i]) inflight[i].dropped = 1'b1;
            m_fetch = {bus.pc_data_q_i[31:2], 2'b00};
         end else begin
            if (pop_q) void'(mq.pop_front());
            if (bus.icache_rsp_v_i && !r.dropped && !byp)
               mq.push_back('{instr: ifn(r.adr), pc: r.adr});
            if (fire) begin
               inflight.push_back('{adr: m_fetch, dropped: 1'b0});
               m_fetch = m_fetch + 32'd4;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_update();
   endtask

   task automatic step(input logic g, input logic rdy, input logic br,
                       input logic [31:0] tgt, input logic ren);
      tick();
      #1;
      bus.icache_gnt_i   = g;
      bus.dec_ready_i    = rdy;
      bus.branch_v_q_i   = br;
      bus.pc_data_q_i    = tgt;
      bus.icache_rsp_v_i = ren && (inflight.size() > 0);
      bus.icache_instr_i = bus.icache_rsp_v_i ? ifn(inflight[0].adr) : '0;
   endtask

   task automatic idle_inputs();
      bus.icache_gnt_i   = 1'b0;
      bus.dec_ready_i    = 1'b0;
      bus.branch_v_q_i   = 1'b0;
      bus.pc_data_q_i    = '0;
      bus.icache_rsp_v_i = 1'b0;
      bus.icache_instr_i = '0;
   endtask

   task automatic release_reset();
      repeat (2) tick();
      #1;
      idle_inputs();
      reset = 1'b0;
      rel_cyc = cyc;
      first_v = -1;
      grants = 0;
      deliv.delete();
      gnt_adr.delete();
   endtask

   task automatic do_reset(input logic [31:0] adr);
      tick();
      #1;
      idle_inputs();
      bus.reset_adr_i = adr;
      reset = 1'b1;
      model_reset();
      release_reset();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_req_v"},   32'(bus.icache_req_v_o), 32'd0);
      check({tag, "_adr"},     bus.icache_adr_o,        32'd0);
      check({tag, "_instr_v"}, 32'(bus.instr_v_o),      32'd0);
      check({tag, "_instr"},   bus.instr_o,             32'd0);
      check({tag, "_pc"},      bus.pc_o,                32'd0);
   endtask

   // Single compare process against the model, plus logs for the literal checks.
   always @(negedge clk) begin
      logic e_req, e_v;
      ent_t e;
      e_req = m_req();
      e_v   = m_instr_v();
      check("req_v", 32'(bus.icache_req_v_o), 32'(e_req));
      if (e_req) check("icache_adr", bus.icache_adr_o, m_fetch);
      check("instr_v", 32'(bus.instr_v_o), 32'(e_v));
      if (e_v) begin
         if (mq.size() > 0) e = mq[0];
         else e = '{instr: ifn(inflight[0].adr), pc: inflight[0].adr};
         check("instr", bus.instr_o, e.instr);
         check("pc", bus.pc_o, e.pc);
      end
      if (bus.icache_req_v_o === 1'b1 && bus.icache_gnt_i === 1'b1) begin
         grants++;
         gnt_adr.push_back(bus.icache_adr_o);
      end
      if (bus.instr_v_o === 1'b1 && bus.dec_ready_i === 1'b1)
         deliv.push_back('{instr: bus.instr_o, pc: bus.pc_o});
      if (bus.instr_v_o === 1'b1 && first_v < 0) first_v = cyc;
   end

   function automatic logic [31:0] dpc(input int i);
      return (deliv.size() > i) ? deliv[i].pc : 32'hXXXX_XXXX;
   endfunction

   function automatic logic [31:0] gadr(input int i);
      return (gnt_adr.size() > i) ? gnt_adr[i] : 32'hXXXX_XXXX;
   endfunction

   initial begin
      idle_inputs();
      bus.reset_adr_i = 32'h8000_0000;
      #1 reset = 1'b1;
      model_reset();
      #2 check_zero_outputs("rst");

      // 1: boot and streaming
      do_reset(32'h8000_0000);
      repeat (10) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t1_first_latency", 32'(first_v - rel_cyc), 32'(FIRST_LAT));
      check("t1_pc0", dpc(0), 32'h8000_0000);
      check("t1_pc1", dpc(1), 32'h8000_0004);
      check("t1_pc2", dpc(2), 32'h8000_0008);
      check("t1_instr0", (deliv.size() > 0) ? deliv[0].instr : 32'hX, 32'h5EAD_BEEF);

      // 2: back-pressure fills the queue, then drains in order
      do_reset(32'h8000_0000);
      repeat (10) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check("t2_grants", 32'(grants), 32'd4);
      check("t2_req_off", 32'(bus.icache_req_v_o), 32'd0);
      check("t2_count", 32'(u_dut.u_fifo.count), 32'd4);
      repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t2_pc0", dpc(0), 32'h8000_0000);
      check("t2_pc1", dpc(1), 32'h8000_0004);
      check("t2_pc2", dpc(2), 32'h8000_0008);
      check("t2_pc3", dpc(3), 32'h8000_000C);
      check("t2_resumed", 32'(grants > 4), 32'd1);

      // 3: flush with 3 outstanding; one response in the flush cycle, two after
      do_reset(32'h8000_0000);
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b1);
      repeat (12) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t3_first_pc", dpc(0), 32'h8000_0100);
      check("t3_first_instr", (deliv.size() > 0) ? deliv[0].instr : 32'hX, 32'h5EAD_BFEF);
      check("t3_target_adr", gadr(3), 32'h8000_0100);
      check("t3_drop_cnt", 32'(u_dut.drop_cnt), 32'd0);

      // 4: flush coinciding with a response and a pop; misaligned target
      do_reset(32'h8000_0000);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h8000_0102, 1'b1);
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t4_count_cleared", 32'(u_dut.u_fifo.count), 32'd0);
      check("t4_outstanding", 32'(u_dut.outstanding), 32'd0);
      repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t4_first_pc", dpc(0), 32'h8000_0100);
      check("t4_target_adr", gadr(3), 32'h8000_0100);

      // 5: PC wrap
      do_reset(32'hFFFF_FFF8);
      repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t5_adr0", gadr(0), 32'hFFFF_FFF8);
      check("t5_adr1", gadr(1), 32'hFFFF_FFFC);
      check("t5_adr2", gadr(2), 32'h0000_0000);
      check("t5_pc2", dpc(2), 32'h0000_0000);

      // 6: async reset with a loaded queue and requests in flight
      do_reset(32'h8000_0000);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check("t6_count", 32'(u_dut.u_fifo.count), 32'd2);
      check("t6_outstanding", 32'(u_dut.outstanding), 32'd2);
      #2;
      reset = 1'b1;
      bus.reset_adr_i = 32'h0000_1000;
      model_reset();
      #1 check_zero_outputs("t6_async");
      release_reset();
      repeat (8) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("t6_first_latency", 32'(first_v - rel_cyc), 32'(FIRST_LAT));
      check("t6_pc0", dpc(0), 32'h0000_1000);
      check("t6_pc1", dpc(1), 32'h0000_1004);

      tick();
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
